// File: rtl/raster_fb_writer.sv
// -----------------------------------------------------------------------------
// raster_fb_writer
//   Sits between the rasterizer and a double-buffered frame buffer. Pixels
//   (x, y, colour) are queued in a small FIFO. The FIFO head is turned into a
//   linear write address in the back buffer. When raster_done arrives, the
//   block drains the FIFO, waits for vsync and swaps the front and back
//   buffers. frame_ready tells the rasterizer when it may emit pixels.
//
//   Optional feature: define RASTER_FB_CLEAR_EN to clear the new back buffer
//   to bk_color after every swap. The default build has no clear state.
//
// Parameters
//   FIFO_DEPTH  pixel FIFO entries (power of 2, >= 4)
//   H_RES       visible width  (pixels with x >= H_RES are dropped)
//   V_RES       visible height (pixels with y >= V_RES are dropped)
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   px_valid     pixel strobe from the rasterizer
//   px_x/px_y    pixel coordinates
//   px_color     pixel colour
//   raster_done  1-cycle pulse: the last pixel of the frame has been issued
//   bk_color     background colour for the clear pass
//   vsync        1-cycle pulse at the start of vertical blank
//   mem_ready    memory accepts the current write
//   frame_ready  rasterizer may issue pixels (registered)
//   mem_we       write strobe
//   mem_addr     {back buffer, y*H_RES + x}
//   mem_wdata    write colour
//   front_buf    buffer currently scanned out by the display
//   swap_done    1-cycle pulse when drawing resumes after a swap
//   overflow     sticky: a pixel was dropped because the FIFO was full or
//                because it arrived outside the drawing phase
// -----------------------------------------------------------------------------
module raster_fb_writer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        px_valid,
  input  logic [9:0]  px_x,
  input  logic [8:0]  px_y,
  input  logic [2:0]  px_color,
  input  logic        raster_done,
  input  logic [2:0]  bk_color,
  input  logic        vsync,
  input  logic        mem_ready,
  output logic        frame_ready,
  output logic        mem_we,
  output logic [19:0] mem_addr,
  output logic [2:0]  mem_wdata,
  output logic        front_buf,
  output logic        swap_done,
  output logic        overflow
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LIN_W  = 19;
  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned C_W    = 3;
  localparam int unsigned ADDR_W = LIN_W + 1;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] color;
  } pixel_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_FLUSH,
    S_WAIT_VS,
    S_SWAP
`ifdef RASTER_FB_CLEAR_EN
    ,
    S_CLEAR
`endif
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Pixel FIFO
  // ---------------------------------------------------------------------------
  pixel_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  pixel_t             head_c;
  pixel_t             in_px_c;
  logic               fifo_full_c;
  logic               fifo_empty_c;
  logic               in_range_c;
  logic               push_c;
  logic               pop_c;
  logic               fifo_rd_c;
  logic [LIN_W-1:0]   head_lin_c;

  assign in_px_c      = '{x: px_x, y: px_y, color: px_color};
  assign head_c       = fifo_mem[rd_ptr];
  assign fifo_full_c  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty_c = (count == '0);
  assign in_range_c   = (32'(px_x) < H_RES) && (32'(px_y) < V_RES);

  // Pixels are only accepted while drawing; anything else is dropped.
  assign push_c = px_valid && (state_q == S_DRAW) && in_range_c && !fifo_full_c;
  assign pop_c  = fifo_rd_c && mem_ready;

  // Linear address of the FIFO head; for H_RES=640 this reduces to
  // (y<<9)+(y<<7)+x after constant propagation.
  assign head_lin_c = LIN_W'(head_c.y) * LIN_W'(H_RES) + LIN_W'(head_c.x);

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_mem[wr_ptr] <= in_px_c;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow: in-range pixel while full, or any pixel outside the drawing phase
  // ---------------------------------------------------------------------------
  logic full_err_c;
  logic proto_err_c;

  assign full_err_c = px_valid && (state_q == S_DRAW) && in_range_c && fifo_full_c;

  always_comb begin
    proto_err_c = 1'b0;
    unique case (state_q)
      S_FLUSH, S_WAIT_VS, S_SWAP: proto_err_c = px_valid;
`ifdef RASTER_FB_CLEAR_EN
      S_CLEAR:                    proto_err_c = px_valid;
`endif
      default:                    proto_err_c = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Clear engine state (feature build only)
  // ---------------------------------------------------------------------------
`ifdef RASTER_FB_CLEAR_EN
  localparam int unsigned LAST_PIX = H_RES * V_RES - 1;

  logic [LIN_W-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
    end
  end
`else
  // bk_color only feeds the clear engine, which is absent in this build.
  logic unused_bk_color;
  assign unused_bk_color = ^bk_color;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, write port and next values of registered outputs
  // ---------------------------------------------------------------------------
  logic              frame_ready_d;
  logic              front_buf_d;
  logic              swap_done_d;
  logic              we_c;
  logic [ADDR_W-1:0] addr_c;
  logic [C_W-1:0]    wdata_c;

  always_comb begin
    state_d       = state_q;
    front_buf_d   = front_buf;
    swap_done_d   = 1'b0;
    fifo_rd_c     = 1'b0;
    we_c          = 1'b0;
    addr_c        = '0;
    wdata_c       = '0;
`ifdef RASTER_FB_CLEAR_EN
    clr_cnt_d     = clr_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        state_d = S_DRAW;
      end

      S_DRAW: begin
        if (!fifo_empty_c) begin
          fifo_rd_c = 1'b1;
          we_c      = 1'b1;
          addr_c    = {~front_buf, head_lin_c};
          wdata_c   = head_c.color;
        end
        if (raster_done) begin
          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (!fifo_empty_c) begin
          fifo_rd_c = 1'b1;
          we_c      = 1'b1;
          addr_c    = {~front_buf, head_lin_c};
          wdata_c   = head_c.color;
        end else begin
          state_d = S_WAIT_VS;
        end
      end

      // vsync is only looked at once this state is reached, so a vsync in
      // the cycle the FIFO empties is deliberately missed.
      S_WAIT_VS: begin
        if (vsync) begin
          state_d     = S_SWAP;
          front_buf_d = ~front_buf;
        end
      end

`ifdef RASTER_FB_CLEAR_EN
      S_SWAP: begin
        state_d   = S_CLEAR;
        clr_cnt_d = '0;
      end

      // One background write per accepted cycle into the new back buffer.
      S_CLEAR: begin
        we_c    = 1'b1;
        addr_c  = {~front_buf, clr_cnt_q};
        wdata_c = bk_color;
        if (mem_ready) begin
          if (clr_cnt_q == LIN_W'(LAST_PIX)) begin
            clr_cnt_d   = '0;
            state_d     = S_DRAW;
            swap_done_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + LIN_W'(1);
          end
        end
      end
`else
      S_SWAP: begin
        state_d     = S_DRAW;
        swap_done_d = 1'b1;
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // One slot of slack covers the registered handshake latency.
    frame_ready_d = (count <= CNT_W'(FIFO_DEPTH - 2)) && (state_q == S_DRAW);
  end

  // Address and data are zero whenever no write is presented.
  assign mem_we    = we_c;
  assign mem_addr  = addr_c;
  assign mem_wdata = wdata_c;

  // Registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_ready <= 1'b0;
      front_buf   <= 1'b0;
      swap_done   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      frame_ready <= frame_ready_d;
      front_buf   <= front_buf_d;
      swap_done   <= swap_done_d;
      overflow    <= overflow | full_err_c | proto_err_c;
    end
  end

endmodule
